// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one start/done iterative multiplier among NREQ requesters.
// Define MULT_TIMEOUT_EN to add a WAIT-state watchdog that returns result=0 with err=1.
module mult_share_arbiter #(
    parameter int W        = 4,
    parameter int NREQ     = 2,
    parameter int TIMEOUT  = 64,
    localparam int IDW     = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*W-1:0]    op_a,
    input  logic [NREQ*W-1:0]    op_b,
    output logic [NREQ-1:0]      ack,
    output logic [2*W-1:0]       result,
    output logic                 err,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 mult_start,
    output logic [W-1:0]         mult_a,
    output logic [W-1:0]         mult_b,
    input  logic                 mult_done,
    input  logic [2*W-1:0]       mult_res
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] eligible;
    logic            pick_valid;
    logic [IDW-1:0]  pick_id;
    logic            timeout_hit;

    // The requester just served is masked for one IDLE cycle so a late-dropping req is not re-granted.
    assign eligible = req & ~mask;

    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!pick_valid && eligible[idx]) begin
                pick_valid = 1'b1;
                pick_id    = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mult_done || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack = '0;
        if (state == RESP) begin
            ack[grant_id] = 1'b1;
        end
    end

    assign busy       = (state != IDLE);
    assign mult_start = (state == ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= IDW'(NREQ - 1);
            mask     <= '0;
            grant_id <= '0;
            mult_a   <= '0;
            mult_b   <= '0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mask <= '0;
                    if (pick_valid) begin
                        grant_id <= pick_id;
                        mult_a   <= op_a[int'(pick_id)*W +: W];
                        mult_b   <= op_b[int'(pick_id)*W +: W];
                    end
                end
                WAIT: begin
                    if (mult_done) begin
                        result <= mult_res;
                    end else if (timeout_hit) begin
                        result <= '0;
                    end
                end
                RESP: begin
                    ptr  <= grant_id;
                    mask <= NREQ'(1) << grant_id;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MULT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    assign timeout_hit = (state == WAIT) && !mult_done && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // err is refreshed only when a transaction completes, so it stays valid alongside ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((state == WAIT) && (mult_done || timeout_hit)) begin
            err <= timeout_hit;
        end
    end
`else
    // Watchdog length has no effect when the watchdog is compiled out.
    localparam int timeout_unused = TIMEOUT;

    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter with a start/done multiplier model.
module tb_mult_share_arbiter;

    localparam int W    = 4;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   op_a;
    logic [NREQ*W-1:0]   op_b;
    logic [NREQ-1:0]     ack;
    logic [2*W-1:0]      result;
    logic                err;
    logic                busy;
    logic [IDW-1:0]      grant_id;
    logic                mult_start;
    logic [W-1:0]        mult_a;
    logic [W-1:0]        mult_b;
    logic                mult_done;
    logic [2*W-1:0]      mult_res;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int         done_delay;
    bit         hold_done;
    int         cnt;
    bit         clear_next;
    logic [7:0] prod;

    mult_share_arbiter #(.W(W), .NREQ(NREQ), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .ack        (ack),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .grant_id   (grant_id),
        .mult_start (mult_start),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_done  (mult_done),
        .mult_res   (mult_res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: done rises done_delay cycles after the start cycle and stays high until the next start.
    // done_delay of 0 means the multiplier never answers; hold_done keeps an old done high through ISSUE.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 0;
            clear_next <= 1'b0;
            mult_done  <= 1'b0;
            mult_res   <= '0;
            prod       <= '0;
        end else begin
            if (clear_next) begin
                mult_done  <= 1'b0;
                clear_next <= 1'b0;
            end
            if (mult_start) begin
                prod <= 8'(mult_a) * 8'(mult_b);
                cnt  <= done_delay;
                if (hold_done) begin
                    clear_next <= 1'b1;
                end else begin
                    mult_done <= 1'b0;
                end
            end else if (cnt == 1) begin
                cnt       <= 0;
                mult_done <= 1'b1;
                mult_res  <= prod;
            end else if (cnt > 1) begin
                cnt <= cnt - 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [3:0] a0, input logic [3:0] b0,
                                 input logic [3:0] a1, input logic [3:0] b1);
        req  = r;
        op_a = {a1, a0};
        op_b = {b1, b0};
    endtask

    task automatic waitStart(input string tag, output int scyc);
        scyc = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (mult_start === 1'b1) begin
                scyc = cyc;
                break;
            end
        end
        if (scyc < 0) checkOutput({tag, "_start_seen"}, 0, 1);
    endtask

    task automatic waitAck(input string tag, input int budget, output int acyc);
        acyc = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (ack !== '0) begin
                acyc = cyc;
                break;
            end
        end
        if (acyc < 0) checkOutput({tag, "_ack_seen"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        int a;
        int t0;
        int bad;
        int exp_id;

        rst_n      = 1'b0;
        done_delay = 8;
        hold_done  = 1'b0;
        applyStimulus(2'b00, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        checkOutput("rst_ack", 32'(ack), 0);
        checkOutput("rst_result", 32'(result), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_grant_id", 32'(grant_id), 0);
        checkOutput("rst_mult_start", 32'(mult_start), 0);
        checkOutput("rst_mult_a", 32'(mult_a), 0);
        checkOutput("rst_mult_b", 32'(mult_b), 0);

        // Test 1: single request 3x5, then a held req[0] must sit out one IDLE cycle
        rst_n = 1'b1;
        @(negedge clk);
        t0 = cyc;
        applyStimulus(2'b01, 3, 5, 0, 0);
        waitStart("t1", s);
        checkOutput("t1_req_to_start", 32'(s - t0), 1);
        checkOutput("t1_mult_a", 32'(mult_a), 3);
        checkOutput("t1_mult_b", 32'(mult_b), 5);
        checkOutput("t1_grant_id", 32'(grant_id), 0);
        waitAck("t1", 40, a);
        checkOutput("t1_ack_latency", 32'(a - s), 9);
        checkOutput("t1_ack", 32'(ack), 1);
        checkOutput("t1_result", 32'(result), 15);
        checkOutput("t1_err", 32'(err), 0);
        @(negedge clk);
        checkOutput("t1_ack_pulse", 32'(ack), 0);
        checkOutput("t1_busy_after", 32'(busy), 0);
        waitStart("t1_again", s);
        checkOutput("t1_masked_gap", 32'(s - a), 3);
        req = 2'b00;
        waitAck("t1_again", 40, a);
        checkOutput("t1_drop_ack", 32'(ack), 1);
        checkOutput("t1_drop_result", 32'(result), 15);
        @(negedge clk);
        checkOutput("t1_drop_busy", 32'(busy), 0);

        // Test 2: simultaneous requests from reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'b11, 2, 4, 7, 9);
        waitStart("t2_first", s);
        checkOutput("t2_first_grant", 32'(grant_id), 0);
        checkOutput("t2_first_mult_a", 32'(mult_a), 2);
        checkOutput("t2_first_mult_b", 32'(mult_b), 4);
        waitAck("t2_first", 40, a);
        checkOutput("t2_first_ack", 32'(ack), 1);
        checkOutput("t2_first_result", 32'(result), 8);
        req = 2'b10;
        waitStart("t2_second", s);
        checkOutput("t2_idle_gap", 32'(s - a), 2);
        checkOutput("t2_second_grant", 32'(grant_id), 1);
        checkOutput("t2_second_mult_a", 32'(mult_a), 7);
        checkOutput("t2_second_mult_b", 32'(mult_b), 9);
        waitAck("t2_second", 40, a);
        checkOutput("t2_second_ack", 32'(ack), 2);
        checkOutput("t2_second_result", 32'(result), 63);
        req = 2'b00;

        // Test 3: both requesters held high alternate
        done_delay = 2;
        @(negedge clk);
        applyStimulus(2'b11, 1, 2, 3, 4);
        for (int k = 0; k < 6; k++) begin
            exp_id = k % 2;
            waitAck($sformatf("t3_%0d", k), 40, a);
            checkOutput($sformatf("t3_grant_%0d", k), 32'(grant_id), 32'(exp_id));
            checkOutput($sformatf("t3_ack_%0d", k), 32'(ack), 32'(1 << exp_id));
            checkOutput($sformatf("t3_result_%0d", k), 32'(result), (exp_id == 1) ? 32'd12 : 32'd2);
        end
        req = 2'b00;

        // Test 4: reset while waiting for done
        done_delay = 20;
        @(negedge clk);
        applyStimulus(2'b10, 0, 0, 5, 7);
        waitStart("t4", s);
        checkOutput("t4_grant_before", 32'(grant_id), 1);
        repeat (3) @(negedge clk);
        checkOutput("t4_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        req   = 2'b00;
        #1;
        checkOutput("t4_rst_result", 32'(result), 0);
        checkOutput("t4_rst_grant", 32'(grant_id), 0);
        checkOutput("t4_rst_mult_a", 32'(mult_a), 0);
        checkOutput("t4_rst_mult_b", 32'(mult_b), 0);
        checkOutput("t4_rst_busy", 32'(busy), 0);
        checkOutput("t4_rst_ack", 32'(ack), 0);
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (ack !== '0) bad++;
        end
        checkOutput("t4_no_ack", 32'(bad), 0);
        rst_n      = 1'b1;
        done_delay = 8;
        applyStimulus(2'b10, 0, 0, 6, 6);
        waitAck("t4_after", 40, a);
        checkOutput("t4_after_ack", 32'(ack), 2);
        checkOutput("t4_after_result", 32'(result), 36);
        checkOutput("t4_after_grant", 32'(grant_id), 1);

        // Test 5a: stale done still high during ISSUE must be ignored
        hold_done = 1'b1;
        applyStimulus(2'b01, 2, 7, 0, 0);
        waitStart("t5a", s);
        waitAck("t5a", 40, a);
        checkOutput("t5a_ack_latency", 32'(a - s), 9);
        checkOutput("t5a_ack", 32'(ack), 1);
        checkOutput("t5a_result", 32'(result), 14);
        req       = 2'b00;
        hold_done = 1'b0;

        // Test 5b: the multiplier never answers
        done_delay = 0;
        @(negedge clk);
        applyStimulus(2'b01, 4, 4, 0, 0);
        waitStart("t5b", s);
`ifdef MULT_TIMEOUT_EN
        waitAck("t5b", 100, a);
        checkOutput("t5b_timeout_latency", 32'(a - s), 65);
        checkOutput("t5b_ack", 32'(ack), 1);
        checkOutput("t5b_err", 32'(err), 1);
        checkOutput("t5b_result", 32'(result), 0);
        done_delay = 3;
        waitAck("t5b_recover", 40, a);
        checkOutput("t5b_recover_result", 32'(result), 16);
        checkOutput("t5b_recover_err", 32'(err), 0);
        req = 2'b00;
`else
        bad = 0;
        repeat (210) begin
            @(negedge clk);
            if (busy !== 1'b1 || ack !== '0 || err !== 1'b0) bad++;
        end
        checkOutput("t5b_stuck_cycles", 32'(bad), 0);
        checkOutput("t5b_busy", 32'(busy), 1);
        checkOutput("t5b_err", 32'(err), 0);
        req   = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
